pulse_period_monitor: RTL and testbench
=======================================

# pulse_period_monitor

Receive-side checker for the periodic single-cycle `sig` pulse produced by the delay/period generator. It measures the interval between consecutive pulses and compares it against a tolerance window around the nominal period. It reports lock after a run of in-window intervals, and reports early or late (missing) pulses. It sits on the consumer side of the generator's `sig` line and feeds the system health/status logic.

## Interface
- `PERIOD`, default 5001: nominal pulse interval in cycles (rising-edge `sig` to next `sig`).
- `TOL`, default 2: allowed deviation in cycles; window is PERIOD-TOL .. PERIOD+TOL inclusive.
- `LOCK_CNT`, default 4: consecutive in-window intervals required to assert `lock`.
- `CBITS`, default 13: interval counter width; must satisfy 2^CBITS > PERIOD+TOL (elaboration-time check).
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `sig` in 1: pulse input, synchronous to `clk`, one cycle high per period.
- `lock` out 1: level, high while tracking with ≥ LOCK_CNT consecutive good intervals.
- `early` out 1: one-cycle pulse, interval shorter than PERIOD-TOL.
- `late` out 1: one-cycle pulse, no `sig` within PERIOD+TOL cycles.
- `period_out` out CBITS: last measured interval; updated on every `sig` in TRACK.
- `miss_cnt` out 8: count of `late` events, saturating at 255.

## Operation
- States: IDLE, TRACK, LOST.
  - IDLE: waits for the first `sig`.
  - TRACK: judges each interval.
  - LOST: entered on `late`; waits to resynchronise.
- Counter `cnt` holds cycles since the last pulse:
  - On `sig`: `cnt` <= 0.
  - Otherwise: `cnt` <= `cnt`+1, saturating at all-ones.
  - `cnt` is held at 0 in IDLE.
- Interval = `cnt`+1, evaluated in the `sig` cycle. Compute it CBITS+1 wide; no wrap.
- IDLE + `sig` → TRACK. The interval is not judged. `good` cleared.
- TRACK + `sig`:
  - Interval < PERIOD-TOL: `early` pulses, `good` <= 0, `lock` <= 0. Stay in TRACK.
  - Interval in window: `good` <= min(`good`+1, LOCK_CNT); `lock` <= 1 when `good`+1 ≥ LOCK_CNT.
  - In both cases `period_out` <= interval.
- TRACK, `sig`=0 and `cnt` == PERIOD+TOL-1 (the pulse would now be out of window):
  - `late` pulses, `lock` <= 0, `good` <= 0, `miss_cnt`++ (saturating).
  - Next state LOST.
- LOST + `sig` → TRACK, `cnt` <= 0. The interval is not judged. `period_out` unchanged.
- `sig` held high on consecutive cycles: each high cycle counts as a pulse, giving interval 1, which is early unless PERIOD-TOL ≤ 1.
- `sig` on exactly `cnt` == PERIOD+TOL-1: in window. `late` is not raised. `sig` takes priority.

## Timing
- All outputs are registered. `early`, `lock` and `period_out` reflect the `sig` in cycle t at cycle t+1.
- `late` is asserted the cycle after `cnt` reaches PERIOD+TOL-1 with `sig` low.
- Reset values: `lock`=0, `early`=0, `late`=0, `period_out`=0, `miss_cnt`=0, `cnt`=0, `good`=0, state=IDLE.
- Reset asserted mid-interval clears everything immediately, with no pending pulse. The first `sig` after release is the IDLE→TRACK event.

## Configuration
- Macro: `PULSE_PERIOD_MONITOR_STICKY_EN`.
- Defined: `early` and `late` become sticky levels. Once set, each stays high until `rst`. `lock` behaviour is unchanged.
- Undefined: `early` and `late` are single-cycle pulses as described above.
- `miss_cnt` increments once per late event in both builds.

## Structure
- Package `pulse_mon_pkg` holds:
  - state enum `pmon_state_t` (IDLE, TRACK, LOST);
  - a shared compare-result enum (EARLY, IN_WIN, LATE).
- Sub-module `pulse_window_cmp`: combinational classification of interval against PERIOD±TOL. Instantiated once; reused by future checkers.
- Top level holds the counter, FSM and output registers.

## Test plan
Overrides for all scenarios: PERIOD=8, TOL=1, LOCK_CNT=3.
- Pulses every 8 cycles ×5 after reset → no `early`/`late`; `lock` rises 1 cycle after the 4th pulse (3rd judged interval); `period_out`=8.
- After lock, one interval of 6 → `early` 1-cycle pulse and `lock`=0 one cycle after that `sig`; three further intervals of 8 → `lock` returns.
- After lock, `sig` withheld → `late` 9 cycles after the last `sig` (the cycle after `cnt`=8); `miss_cnt`=1; state LOST. Next `sig` → TRACK with `period_out` unchanged.
- Intervals of 7 and of 9 (window edges) → no errors. Interval of 10 is impossible: `late` fires first.
- `rst` asserted at `cnt`=5 while locked → all outputs 0 asynchronously. After release, a `sig` every 8 cycles needs 4 pulses to re-lock.
- With `PULSE_PERIOD_MONITOR_STICKY_EN` defined, provoke one early interval → `early` stays 1 through subsequent good intervals until `rst`.

Source files
------------

// File: rtl/pulse_mon_pkg.sv
// Shared types for the pulse period checkers: FSM states, window classification, saturating helpers.
package pulse_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    LOST  = 2'd2
  } pmon_state_t;

  typedef enum logic [1:0] {
    EARLY  = 2'd0,
    IN_WIN = 2'd1,
    LATE   = 2'd2
  } win_res_t;

  localparam int MISS_W = 8;

  function automatic logic [MISS_W-1:0] sat_inc8(input logic [MISS_W-1:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pulse_window_cmp.sv
// Combinational classification of a measured interval against PERIOD +/- TOL (inclusive window).
module pulse_window_cmp
  import pulse_mon_pkg::*;
#(
  parameter int PERIOD = 5001,
  parameter int TOL    = 2,
  parameter int CBITS  = 13
) (
  input  logic [CBITS:0] interval,
  output win_res_t       res
);

  // Lower edge clamps at zero so TOL >= PERIOD still elaborates cleanly
  localparam int LO = (PERIOD > TOL) ? (PERIOD - TOL) : 0;
  localparam int HI = PERIOD + TOL;
  localparam logic [CBITS:0] LO_V = LO[CBITS:0];
  localparam logic [CBITS:0] HI_V = HI[CBITS:0];

  // Three-way compare of the interval against the window edges
  always_comb begin
    res = IN_WIN;
    if (interval < LO_V) begin
      res = EARLY;
    end else if (interval > HI_V) begin
      res = LATE;
    end else begin
      res = IN_WIN;
    end
  end

endmodule

// File: rtl/pulse_period_monitor.sv
// Pulse period monitor: interval counter, IDLE/TRACK/LOST FSM and registered status outputs.
// Build option PULSE_PERIOD_MONITOR_STICKY_EN makes early/late sticky until reset.
module pulse_period_monitor
  import pulse_mon_pkg::*;
#(
  parameter int PERIOD   = 5001,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4,
  parameter int CBITS    = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  output logic             lock,
  output logic             early,
  output logic             late,
  output logic [CBITS-1:0] period_out,
  output logic [7:0]       miss_cnt
);

  if ((2 ** CBITS) <= (PERIOD + TOL)) begin : g_cbits_check
    $error("pulse_period_monitor: CBITS too small for PERIOD+TOL");
  end

  localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int LATE_AT = PERIOD + TOL - 1;
  localparam logic [CBITS-1:0] LATE_AT_V = LATE_AT[CBITS-1:0];
  localparam logic [GW:0] LOCK_V = LOCK_CNT[GW:0];

  pmon_state_t      state_r;
  logic [CBITS-1:0] cnt_r;
  logic [GW-1:0]    good_r;
  logic             lock_r;
  logic             early_r;
  logic             late_r;
  logic [CBITS-1:0] period_r;
  logic [7:0]       miss_r;

  logic [CBITS:0]   interval_s;
  logic [CBITS-1:0] cnt_inc_s;
  logic [GW:0]      good_nx_s;
  logic             late_hit_s;
  win_res_t         res_s;

  assign interval_s = {1'b0, cnt_r} + {{CBITS{1'b0}}, 1'b1};
  assign cnt_inc_s  = (&cnt_r) ? cnt_r : cnt_r + {{(CBITS-1){1'b0}}, 1'b1};
  assign good_nx_s  = {1'b0, good_r} + {{GW{1'b0}}, 1'b1};
  assign late_hit_s = (cnt_r == LATE_AT_V);

  pulse_window_cmp #(
    .PERIOD (PERIOD),
    .TOL    (TOL),
    .CBITS  (CBITS)
  ) u_cmp (
    .interval (interval_s),
    .res      (res_s)
  );

  // Counter, FSM and all output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      good_r   <= '0;
      lock_r   <= 1'b0;
      early_r  <= 1'b0;
      late_r   <= 1'b0;
      period_r <= '0;
      miss_r   <= 8'd0;
    end else begin
`ifdef PULSE_PERIOD_MONITOR_STICKY_EN
      early_r <= early_r;
      late_r  <= late_r;
`else
      early_r <= 1'b0;
      late_r  <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (sig) begin
            state_r <= TRACK;
            good_r  <= '0;
          end
        end
        TRACK: begin
          if (sig) begin
            // sig wins over the late check on the last in-window cycle
            cnt_r    <= '0;
            period_r <= interval_s[CBITS-1:0];
            case (res_s)
              EARLY: begin
                early_r <= 1'b1;
                good_r  <= '0;
                lock_r  <= 1'b0;
              end
              IN_WIN: begin
                if (good_nx_s >= LOCK_V) begin
                  good_r <= LOCK_V[GW-1:0];
                  lock_r <= 1'b1;
                end else begin
                  good_r <= good_nx_s[GW-1:0];
                end
              end
              default: begin
                good_r <= '0;
                lock_r <= 1'b0;
              end
            endcase
          end else if (late_hit_s) begin
            cnt_r   <= cnt_inc_s;
            late_r  <= 1'b1;
            lock_r  <= 1'b0;
            good_r  <= '0;
            miss_r  <= sat_inc8(miss_r);
            state_r <= LOST;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        LOST: begin
          if (sig) begin
            state_r <= TRACK;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign lock       = lock_r;
  assign early      = early_r;
  assign late       = late_r;
  assign period_out = period_r;
  assign miss_cnt   = miss_r;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Scoreboard bench for pulse_period_monitor with PERIOD=8, TOL=1, LOCK_CNT=3, CBITS=4.
module tb_pulse_period_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig = 1'b0;
  logic       lock;
  logic       early;
  logic       late;
  logic [3:0] period_out;
  logic [7:0] miss_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_sig_cyc = 0;
  logic done = 1'b0;

  typedef struct {
    int         cyc;
    logic       lock;
    logic       early;
    logic       late;
    logic [3:0] per;
    logic [7:0] miss;
  } exp_t;

  exp_t q[$];

  pulse_period_monitor #(
    .PERIOD   (8),
    .TOL      (1),
    .LOCK_CNT (3),
    .CBITS    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sig        (sig),
    .lock       (lock),
    .early      (early),
    .late       (late),
    .period_out (period_out),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic slot(input logic v);
    sig = v;
    @(posedge clk);
    #1;
  endtask

  // gap = cycles from previous sig to this one; expectation lands the cycle after sampling
  task automatic pulse(input int gap, input logic e_lock, input logic e_early,
                       input int e_per, input int e_miss);
    exp_t e;
    for (int i = 0; i < gap - 1; i++) slot(1'b0);
    e.cyc   = cyc + 1;
    e.lock  = e_lock;
    e.early = e_early;
    e.late  = 1'b0;
    e.per   = e_per[3:0];
    e.miss  = e_miss[7:0];
    q.push_back(e);
    last_sig_cyc = e.cyc;
    slot(1'b1);
    sig = 1'b0;
  endtask

  task automatic expect_late(input int e_per, input int e_miss);
    exp_t e;
    e.cyc   = last_sig_cyc + 9;
    e.lock  = 1'b0;
    e.early = 1'b0;
    e.late  = 1'b1;
    e.per   = e_per[3:0];
    e.miss  = e_miss[7:0];
    q.push_back(e);
  endtask

  // Monitor: pops expected events on their cycle, otherwise checks held state and no stray pulses
  initial begin : monitor
    logic       h_lock;
    logic [3:0] h_per;
    logic [7:0] h_miss;
    logic       lvl_early;
    logic       lvl_late;
    exp_t       e;
    h_lock = 1'b0; h_per = 4'd0; h_miss = 8'd0; lvl_early = 1'b0; lvl_late = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rst) begin
        h_lock = 1'b0; h_per = 4'd0; h_miss = 8'd0; lvl_early = 1'b0; lvl_late = 1'b0;
        chk("rst_lock", lock, 0);
        chk("rst_early", early, 0);
        chk("rst_late", late, 0);
        chk("rst_period", period_out, 0);
        chk("rst_miss", miss_cnt, 0);
      end else begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          chk("event_missed_cycle", cyc, e.cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          chk("ev_lock", lock, e.lock);
          chk("ev_early", early, e.early | lvl_early);
          chk("ev_late", late, e.late | lvl_late);
          chk("ev_period", period_out, e.per);
          chk("ev_miss", miss_cnt, e.miss);
          h_lock = e.lock; h_per = e.per; h_miss = e.miss;
`ifdef PULSE_PERIOD_MONITOR_STICKY_EN
          lvl_early = lvl_early | e.early;
          lvl_late  = lvl_late | e.late;
`endif
        end else begin
          chk("idle_lock", lock, h_lock);
          chk("idle_early", early, lvl_early);
          chk("idle_late", late, lvl_late);
          chk("idle_period", period_out, h_per);
          chk("idle_miss", miss_cnt, h_miss);
        end
      end
    end
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    slot(1'b0);

    // acquire: first pulse unjudged, lock after third judged interval
    pulse(3, 1'b0, 1'b0, 0, 0);
    pulse(8, 1'b0, 1'b0, 8, 0);
    pulse(8, 1'b0, 1'b0, 8, 0);
    pulse(8, 1'b1, 1'b0, 8, 0);
    pulse(8, 1'b1, 1'b0, 8, 0);

    // early interval drops lock, three good intervals restore it
    pulse(6, 1'b0, 1'b1, 6, 0);
    pulse(8, 1'b0, 1'b0, 8, 0);
    pulse(8, 1'b0, 1'b0, 8, 0);
    pulse(8, 1'b1, 1'b0, 8, 0);

    // window edges 7 and 9 are good
    pulse(7, 1'b1, 1'b0, 7, 0);
    pulse(9, 1'b1, 1'b0, 9, 0);
    pulse(7, 1'b1, 1'b0, 7, 0);

    // missing pulse: late 9 cycles after last sig, then resync without judging
    expect_late(7, 1);
    repeat (12) slot(1'b0);
    pulse(1, 1'b0, 1'b0, 7, 1);
    pulse(8, 1'b0, 1'b0, 8, 1);
    pulse(8, 1'b0, 1'b0, 8, 1);
    pulse(8, 1'b1, 1'b0, 8, 1);

    // async reset at cnt=5 while locked
    repeat (5) slot(1'b0);
    rst = 1'b1;
    #2;
    chk("async_lock", lock, 0);
    chk("async_period", period_out, 0);
    chk("async_miss", miss_cnt, 0);
    chk("async_late", late, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulse(3, 1'b0, 1'b0, 0, 0);
    pulse(8, 1'b0, 1'b0, 8, 0);
    pulse(8, 1'b0, 1'b0, 8, 0);
    pulse(8, 1'b1, 1'b0, 8, 0);

    // sig held high two cycles: interval 1 is early
    pulse(1, 1'b0, 1'b1, 1, 0);
    pulse(8, 1'b0, 1'b0, 8, 0);

    repeat (4) slot(1'b0);
    chk("queue_drained", q.size(), 0);
    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
